// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-only data memory: sub-word load extraction, RMW sub-word stores, faults.
// Loads and SW take 1 cycle with the result registered. SB/SH take 2 cycles and hold stall high in the first.
module mem_access_unit #(
   parameter logic [31:0] MEM_BASE = 32'h0000_0000,
   parameter int unsigned MEM_SIZE = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        stall,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_rd,
   output logic        fault_valid,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_addr
);
   localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

   typedef enum logic [0:0] {IDLE, RMW_WR} state_t;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] addr;
      logic [15:0] wdata;
      logic        half;
   } rmw_t;

   state_t      state_q, state_d;
   rmw_t        rmw_q, rmw_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [4:0]  resp_rd_q, resp_rd_d;
   logic        fault_valid_q, fault_valid_d;
   logic [1:0]  fault_cause_q, fault_cause_d;
   logic [31:0] fault_addr_q, fault_addr_d;

   logic        illegal, misaligned, in_range;
   logic [32:0] offset;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;
   logic [31:0] merged;

   always_comb begin
      illegal    = (req_funct3 == 3'b011) || (req_funct3[2] && (req_write || req_funct3[1]));
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
      // 33-bit difference: the borrow bit catches addresses below the base.
      offset     = {1'b0, req_addr} - {1'b0, MEM_BASE};
      in_range   = !offset[32] && (offset[31:0] < MEM_LIMIT);

      case (req_addr[1:0])
         2'd0:    ld_byte = mem_rdata[7:0];
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (req_funct3)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'h0, ld_byte};
         3'b101:  ld_ext = {16'h0, ld_half};
         default: ld_ext = mem_rdata;
      endcase

      merged = rmw_q.word;
      if (rmw_q.half) begin
         if (rmw_q.addr[1]) merged[31:16] = rmw_q.wdata;
         else               merged[15:0]  = rmw_q.wdata;
      end else begin
         case (rmw_q.addr[1:0])
            2'd0:    merged[7:0]   = rmw_q.wdata[7:0];
            2'd1:    merged[15:8]  = rmw_q.wdata[7:0];
            2'd2:    merged[23:16] = rmw_q.wdata[7:0];
            default: merged[31:24] = rmw_q.wdata[7:0];
         endcase
      end
   end

   always_comb begin
      state_d       = state_q;
      rmw_d         = rmw_q;
      stall         = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_addr      = {req_addr[31:2], 2'b00};
      mem_wdata     = req_wdata;
      resp_valid_d  = 1'b0;
      resp_rdata_d  = 32'h0;
      resp_rd_d     = 5'h0;
      fault_valid_d = 1'b0;
      fault_cause_d = 2'b00;
      fault_addr_d  = 32'h0;

      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  if (illegal || misaligned || !in_range) begin
                     fault_valid_d = 1'b1;
                     fault_addr_d  = req_addr;
                     fault_cause_d = illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b10);
                  end else if (!req_write) begin
                     mem_read     = 1'b1;
                     resp_valid_d = 1'b1;
                     resp_rdata_d = ld_ext;
                     resp_rd_d    = req_rd;
                  end else if (req_funct3 == 3'b010) begin
                     mem_write = 1'b1;
                  end else begin
                     stall    = 1'b1;
                     mem_read = 1'b1;
                     rmw_d    = '{word: mem_rdata, addr: req_addr,
                                  wdata: req_wdata[15:0], half: req_funct3[0]};
                     state_d  = RMW_WR;
                  end
               end
            end
            RMW_WR: begin
               // The held request is the same store; it is not re-examined.
               mem_write = 1'b1;
               mem_addr  = {rmw_q.addr[31:2], 2'b00};
               mem_wdata = merged;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rmw_q         <= '0;
         resp_valid_q  <= 1'b0;
         resp_rdata_q  <= 32'h0;
         resp_rd_q     <= 5'h0;
         fault_valid_q <= 1'b0;
         fault_cause_q <= 2'b00;
         fault_addr_q  <= 32'h0;
      end else begin
         state_q       <= state_d;
         rmw_q         <= rmw_d;
         resp_valid_q  <= resp_valid_d;
         resp_rdata_q  <= resp_rdata_d;
         resp_rd_q     <= resp_rd_d;
         fault_valid_q <= fault_valid_d;
         fault_cause_q <= fault_cause_d;
         fault_addr_q  <= fault_addr_d;
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_rd     = resp_rd_q;
   assign fault_valid = fault_valid_q;
   assign fault_cause = fault_cause_q;
   assign fault_addr  = fault_addr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory behind it.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        stall, mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        fault_valid;
   logic [1:0]  fault_cause;
   logic [31:0] fault_addr;

   logic [31:0] mem [0:255];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_writes = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_BASE(32'h0), .MEM_SIZE(1024)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .stall(stall), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
      .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr)
   );

   assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'hz;

   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_addr[9:2]] <= mem_wdata;
         n_writes <= n_writes + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      req_valid  = v;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_rd     = rd;
   endtask

   // Advance one cycle: sample combinational outputs at the falling edge, return 1ns after the rising edge.
   task automatic half_step();
      @(negedge clk);
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [4:0] rd, input logic [31:0] exp);
      drive(1'b1, 1'b0, f3, a, 32'h0, rd);
      half_step();
      chk({tag, "_rd_strobe"}, {31'h0, mem_read}, 32'h1);
      chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
      finish_cycle();
      chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
      chk({tag, "_data"}, resp_rdata, exp);
      chk({tag, "_dest"}, {27'h0, resp_rd}, {27'h0, rd});
   endtask

   task automatic fault(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] cause);
      drive(1'b1, w, f3, a, 32'h5555_5555, 5'd3);
      half_step();
      chk({tag, "_no_access"}, {30'h0, mem_read, mem_write}, 32'h0);
      chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
      finish_cycle();
      chk({tag, "_fvalid"}, {31'h0, fault_valid}, 32'h1);
      chk({tag, "_cause"}, {30'h0, fault_cause}, {30'h0, cause});
      chk({tag, "_faddr"}, fault_addr, a);
      chk({tag, "_no_resp"}, {31'h0, resp_valid}, 32'h0);
   endtask

   task automatic sub_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_word);
      drive(1'b1, 1'b1, f3, a, wd, 5'd0);
      half_step();
      chk({tag, "_stall1"}, {31'h0, stall}, 32'h1);
      chk({tag, "_read1"}, {30'h0, mem_read, mem_write}, 32'h2);
      finish_cycle();
      half_step();
      chk({tag, "_stall2"}, {31'h0, stall}, 32'h0);
      chk({tag, "_write2"}, {31'h0, mem_write}, 32'h1);
      chk({tag, "_waddr"}, mem_addr, {a[31:2], 2'b00});
      chk({tag, "_wdata"}, mem_wdata, exp_word);
      finish_cycle();
      chk({tag, "_no_resp"}, {31'h0, resp_valid}, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h08] = 32'h80FF_7F01;
      mem[8'h0C] = 32'hCAFE_F00D;

      // Reset with a request presented: no memory traffic, no stall.
      rst = 1'b1;
      drive(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd1);
      half_step();
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_mem", {30'h0, mem_read, mem_write}, 32'h0);
      finish_cycle();
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
      finish_cycle();
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_rd", {27'h0, resp_rd}, 32'h0);
      chk("rst_fault_valid", {31'h0, fault_valid}, 32'h0);
      chk("rst_fault_cause", {30'h0, fault_cause}, 32'h0);
      chk("rst_fault_addr", fault_addr, 32'h0);
      rst = 1'b0;

      // SW then LW back.
      drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h1122_3344, 5'd0);
      half_step();
      chk("sw_write", {31'h0, mem_write}, 32'h1);
      chk("sw_stall", {31'h0, stall}, 32'h0);
      chk("sw_addr", mem_addr, 32'h10);
      chk("sw_wdata", mem_wdata, 32'h1122_3344);
      finish_cycle();
      chk("sw_no_resp", {31'h0, resp_valid}, 32'h0);
      load("lw10", 3'b010, 32'h10, 5'd5, 32'h1122_3344);

      // SB into lane 2 by read-modify-write.
      sub_store("sb12", 3'b000, 32'h12, 32'h0000_00AA, 32'h11AA_3344);
      load("lw10_after_sb", 3'b010, 32'h10, 5'd6, 32'h11AA_3344);

      // Sub-word loads from 0x80FF_7F01.
      load("lb21", 3'b000, 32'h21, 5'd7, 32'h0000_007F);
      load("lb22", 3'b000, 32'h22, 5'd8, 32'hFFFF_FFFF);
      load("lbu22", 3'b100, 32'h22, 5'd9, 32'h0000_00FF);
      load("lh22", 3'b001, 32'h22, 5'd10, 32'hFFFF_80FF);
      load("lhu22", 3'b101, 32'h22, 5'd11, 32'h0000_80FF);
      load("lh20", 3'b001, 32'h20, 5'd12, 32'h0000_7F01);
      load("lb23_x0", 3'b000, 32'h23, 5'd0, 32'hFFFF_FF80);

      // Faults and their priority.
      fault("lw13_misal", 1'b0, 3'b010, 32'h13, 2'b01);
      fault("sw400_range", 1'b1, 3'b010, 32'h400, 2'b10);
      fault("f3_011", 1'b0, 3'b011, 32'h10, 2'b11);
      fault("shu_illegal", 1'b1, 3'b101, 32'h11, 2'b11);
      fault("lh401_misal", 1'b0, 3'b001, 32'h401, 2'b01);
      fault("lw_ffff_range", 1'b0, 3'b010, 32'hFFFF_FFFC, 2'b10);

      // Last legal word.
      drive(1'b1, 1'b1, 3'b010, 32'h3FC, 32'h0BAD_F00D, 5'd0);
      half_step();
      chk("sw3fc_write", {31'h0, mem_write}, 32'h1);
      finish_cycle();
      chk("sw3fc_no_fault", {31'h0, fault_valid}, 32'h0);

      // Idle cycle clears registered outputs.
      drive(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 5'd4);
      half_step();
      chk("idle_mem", {30'h0, mem_read, mem_write}, 32'h0);
      finish_cycle();
      chk("idle_resp", {31'h0, resp_valid}, 32'h0);
      chk("idle_fault", {31'h0, fault_valid}, 32'h0);
      chk("mem3fc", mem[8'hFF], 32'h0BAD_F00D);

      // SH interrupted by reset in the write cycle.
      drive(1'b1, 1'b1, 3'b001, 32'h30, 32'h0000_BEEF, 5'd0);
      half_step();
      chk("shrst_stall", {31'h0, stall}, 32'h1);
      finish_cycle();
      rst = 1'b1;
      n_writes = 0;
      half_step();
      chk("shrst_no_write", {31'h0, mem_write}, 32'h0);
      finish_cycle();
      rst = 1'b0;
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
      half_step();
      chk("shrst_idle_write", {31'h0, mem_write}, 32'h0);
      finish_cycle();
      chk("shrst_write_count", n_writes, 32'h0);
      chk("shrst_mem", mem[8'h0C], 32'hCAFE_F00D);
      load("shrst_lw30", 3'b010, 32'h30, 5'd2, 32'hCAFE_F00D);

      // Upper-half SH completes normally.
      sub_store("sh32", 3'b001, 32'h32, 32'h1234_BEEF, 32'hBEEF_F00D);
      load("lw30_after_sh", 3'b010, 32'h30, 5'd13, 32'hBEEF_F00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
